// File: rtl/pio_pkg.sv
// pio_pkg: register offsets and edge-type codes shared by the PIO family.
package pio_pkg;
    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;
endpackage

// File: rtl/pio_sync_chain.sv
// pio_sync_chain: multi-stage flop synchroniser for asynchronous input buses.
module pio_sync_chain #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [STAGES-1:0][WIDTH-1:0] r_stages;
    always_ff @(posedge clk or posedge reset)
        if (reset) r_stages <= '0;
        else       r_stages <= {r_stages[STAGES-2:0], i_d};
    assign o_q = r_stages[STAGES-1];
endmodule

// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq: Avalon-MM input PIO with synchroniser, sticky edge capture,
// interrupt mask and registered level IRQ.
module pio_in_edge_irq
    import pio_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_EN      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int CW        = $clog2(PRIME_MAX + 1);
    logic [WIDTH-1:0] w_sync, w_edge, w_clr;
    logic [WIDTH-1:0] r_prev, r_edgecap, r_irqmask;
    logic [CW-1:0]    r_prime;
    logic [31:0]      w_rdata, r_readdata;
    logic             w_primed, w_wr, r_irq, w_unused_wdata;
    pio_sync_chain #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (in_port),
        .o_q   (w_sync)
    );
    // Edges are ignored until prev has seen settled synchroniser output,
    // so inputs already high at reset release never look like an edge.
    assign w_primed = r_prime == CW'(PRIME_MAX);
    assign w_wr     = chipselect && write;
    assign w_edge   = !w_primed                  ? '0 :
                      EDGE_TYPE == EDGE_RISING  ? (w_sync & ~r_prev) :
                      EDGE_TYPE == EDGE_FALLING ? (~w_sync & r_prev) :
                                                  (w_sync ^ r_prev);
    assign w_clr    = (w_wr && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    assign w_rdata  = address == PIO_ADDR_DATA    ? 32'(w_sync) :
                      address == PIO_ADDR_IRQMASK ? 32'(r_irqmask) :
                      address == PIO_ADDR_EDGECAP ? 32'(r_edgecap) : 32'd0;
    assign w_unused_wdata = &{1'b0, writedata};
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_prev     <= '0;
            r_edgecap  <= '0;
            r_irqmask  <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
            r_prime    <= '0;
        end else begin
            r_prev     <= w_sync;
            r_edgecap  <= (r_edgecap & ~w_clr) | w_edge;
            r_readdata <= w_rdata;
            r_irq      <= (IRQ_EN != 0) && |(r_edgecap & r_irqmask);
            if (!w_primed) r_prime <= r_prime + CW'(1);
            if (IRQ_EN != 0 && w_wr && address == PIO_ADDR_IRQMASK)
                r_irqmask <= writedata[WIDTH-1:0];
        end
    assign readdata = r_readdata;
    assign irq      = r_irq;
endmodule

// File: tb/tb_pio_in_edge_irq.sv
// tb_pio_in_edge_irq: scoreboard bench driving rising, falling and any-edge
// instances from one stimulus stream against a cycle-level reference model.
module tb_pio_in_edge_irq;
    localparam int W = 6;
    localparam int S = 2;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic [W-1:0]  in_port = 6'h3F;
    logic [31:0]   rd [3];
    logic          irq [3];
    typedef struct packed {
        logic [2:0][31:0] rd;
        logic [2:0]       irq;
        int               step;
    } exp_t;
    exp_t          sb_q[$];
    logic [W-1:0]  hist[$];
    logic [W-1:0]  m_cap [3];
    logic [W-1:0]  m_mask;
    int            m_e;
    int            n_pass = 0;
    int            n_total = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        pio_in_edge_irq #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(g), .IRQ_EN(1)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .address    (address),
            .chipselect (chipselect),
            .write      (write),
            .writedata  (writedata),
            .in_port    (in_port),
            .readdata   (rd[g]),
            .irq        (irq[g])
        );
    end
    task automatic chk(input string name, input int step, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", name, step, got, exp);
    endtask
    function automatic logic [W-1:0] sync_at(input int k);
        return k < hist.size() ? hist[k] : '0;
    endfunction
    task automatic model_reset();
        hist.delete();
        m_e = 0;
        m_mask = '0;
        for (int t = 0; t < 3; t++) m_cap[t] = '0;
    endtask
    // Called at a falling edge; drives one cycle and records the expected outputs.
    task automatic step(input logic [W-1:0] inp, input logic [1:0] a, input logic cs,
                        input logic wr, input logic [31:0] wd);
        exp_t x;
        logic [W-1:0] s1, s2, ed, clr;
        in_port = inp; address = a; chipselect = cs; write = wr; writedata = wd;
        @(posedge clk);
        m_e++;
        s1  = sync_at(S - 1);
        s2  = sync_at(S);
        clr = (cs && wr && a == 2'd3) ? wd[W-1:0] : '0;
        for (int t = 0; t < 3; t++) begin
            x.rd[t]  = a == 2'd0 ? 32'(s1) : a == 2'd2 ? 32'(m_mask) : a == 2'd3 ? 32'(m_cap[t]) : 32'd0;
            x.irq[t] = |(m_cap[t] & m_mask);
            ed = m_e < S + 2 ? '0 : t == 0 ? (s1 & ~s2) : t == 1 ? (~s1 & s2) : (s1 ^ s2);
            m_cap[t] = (m_cap[t] & ~clr) | ed;
        end
        if (cs && wr && a == 2'd2) m_mask = wd[W-1:0];
        hist.push_front(inp);
        if (hist.size() > S + 1) void'(hist.pop_back());
        x.step = m_e;
        sb_q.push_back(x);
        @(negedge clk);
    endtask
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                for (int t = 0; t < 3; t++) begin
                    chk($sformatf("readdata[%0d]", t), x.step, rd[t], x.rd[t]);
                    chk($sformatf("irq[%0d]", t), x.step, 32'(irq[t]), 32'(x.irq[t]));
                end
            end
        end
    end
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin : driver
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) step(6'h3F, 2'd3, 1'b0, 1'b0, 32'h0);
        repeat (2)  step(6'h3F, 2'd0, 1'b0, 1'b0, 32'h0);
        repeat (4)  step(6'h00, 2'd0, 1'b0, 1'b0, 32'h0);
        repeat (5)  step(6'h05, 2'd0, 1'b0, 1'b0, 32'h0);
        step(6'h05, 2'd3, 1'b1, 1'b1, 32'h3F);
        step(6'h05, 2'd2, 1'b1, 1'b1, 32'h4);
        repeat (3)  step(6'h01, 2'd3, 1'b0, 1'b0, 32'h0);
        step(6'h01, 2'd3, 1'b1, 1'b1, 32'h3F);
        repeat (5)  step(6'h05, 2'd3, 1'b0, 1'b0, 32'h0);
        step(6'h05, 2'd3, 1'b1, 1'b1, 32'h4);
        repeat (3)  step(6'h05, 2'd3, 1'b0, 1'b0, 32'h0);
        repeat (2)  step(6'h07, 2'd3, 1'b0, 1'b0, 32'h0);
        step(6'h07, 2'd3, 1'b1, 1'b1, 32'h2);
        repeat (2)  step(6'h07, 2'd3, 1'b0, 1'b0, 32'h0);
        step(6'h06, 2'd3, 1'b1, 1'b1, 32'h3F);
        repeat (3)  step(6'h06, 2'd3, 1'b0, 1'b0, 32'h0);
        step(6'h06, 2'd3, 1'b1, 1'b1, 32'h3F);
        repeat (4)  step(6'h07, 2'd3, 1'b0, 1'b0, 32'h0);
        step(6'h07, 2'd3, 1'b1, 1'b1, 32'h1);
        repeat (4)  step(6'h06, 2'd3, 1'b0, 1'b0, 32'h0);
        step(6'h06, 2'd3, 1'b1, 1'b1, 32'h1);
        step(6'h06, 2'd0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        repeat (3)  step(6'h06, 2'd0, 1'b0, 1'b0, 32'h0);
        step(6'h06, 2'd2, 1'b1, 1'b1, 32'h3F);
        step(6'h06, 2'd3, 1'b1, 1'b1, 32'h3F);
        repeat (2)  step(6'h06, 2'd3, 1'b0, 1'b0, 32'h0);
        repeat (4)  step(6'h07, 2'd3, 1'b0, 1'b0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        for (int t = 0; t < 3; t++) begin
            chk($sformatf("async_rst_readdata[%0d]", t), m_e, rd[t], 32'h0);
            chk($sformatf("async_rst_irq[%0d]", t), m_e, 32'(irq[t]), 32'h0);
        end
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2)  step(6'h07, 2'd2, 1'b0, 1'b0, 32'h0);
        repeat (6)  step(6'h07, 2'd3, 1'b0, 1'b0, 32'h0);
        repeat (400)
            step(6'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expected responses left, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pio_in_edge_irq.md
Name: pio_in_edge_irq

Overview:
- Parametrised successor to the fixed 6-bit Avalon-MM input PIO used for board switches and selector lines (e.g. ALU select) in the debug SoC.
- Adds a configurable input width, a metastability synchroniser, per-bit edge capture with write-1-to-clear, an interrupt mask and a level IRQ output.
- Sits as an Avalon-MM slave on the SoC interconnect between off-chip or asynchronous inputs and the RV32IM core.

Parameters:
- WIDTH, 6, number of input bits (1..32).
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser (2..4).
- EDGE_TYPE, 0, captured edge: 0 = rising, 1 = falling, 2 = any.
- IRQ_EN, 1, 1 = irq logic present; 0 = irq tied to 0 and irqmask reads 0.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register word address.
- chipselect  in  1  slave select; qualifies write.
- write  in  1  write strobe.
- writedata  in  32  write data; bits above WIDTH ignored.
- in_port  in  WIDTH  external inputs, asynchronous to clk.
- readdata  out  32  registered read data, zero-extended above WIDTH.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Reset is asynchronous and active-high. On reset, all of the following clear to 0: sync stages, prev register, edgecapture, irqmask, readdata, irq and prime counter.
- Register map:
  - 0 = data (RO, synchronised input).
  - 1 = reserved (reads 0, writes ignored).
  - 2 = irqmask (RW).
  - 3 = edgecapture (read; write-1-to-clear).
- Read:
  - readdata is updated every cycle from the current address: readdata <= zero-extended mux(address).
  - Fixed read latency of 1 cycle. chipselect is not required for reads.
- Write: takes effect only when chipselect && write.
  - Address 2: irqmask <= writedata[WIDTH-1:0].
  - Address 3: edgecapture[i] cleared where writedata[i] = 1.
  - Writes to addresses 0 and 1: no effect.
- Synchroniser:
  - in_port passes through SYNC_STAGES flops to give sync_q.
  - Data register value = sync_q.
  - Input-to-readable latency = SYNC_STAGES cycles, plus 1 cycle of read latency.
- Edge detect: prev <= sync_q every cycle.
  - Rising: sync_q & ~prev.
  - Falling: ~sync_q & prev.
  - Any: sync_q ^ prev.
- Edge capture:
  - Detected edge bits set the corresponding edgecapture bits (sticky).
  - Edge and clear on the same bit in the same cycle: the set wins, so the bit stays 1.
  - Clearing one bit never affects other bits.
- Prime counter:
  - After reset deassertion, a saturating counter runs from 0 to SYNC_STAGES+1.
  - Edge detection is suppressed until the counter saturates, so inputs already high at reset never generate a spurious edge.
  - sync_q and prev still update during this window.
- IRQ:
  - irq is registered: irq <= |(edgecapture & irqmask), one cycle after the cause.
  - Clearing the last masked edge, or clearing its mask bit, drops irq on the following cycle.
- Reset asserted mid-operation: all state clears immediately, the prime window restarts, and any pending irq drops asynchronously.
- Widths: WIDTH = 32 uses the full readdata. For WIDTH < 32, upper readdata bits are constant 0.

Decomposition:
- Shared package pio_pkg:
  - Register offsets: PIO_ADDR_DATA = 0, PIO_ADDR_IRQMASK = 2, PIO_ADDR_EDGECAP = 3.
  - Edge-type constants: EDGE_RISING = 0, EDGE_FALLING = 1, EDGE_ANY = 2.
- One sub-module, pio_sync_chain:
  - Parameters WIDTH and STAGES; asynchronous active-high reset to 0.
  - Reusable by later output and bidirectional PIO blocks.

Test Plan:
- Reset with in_port = 6'h3F held high through release and for 10 cycles, then read address 3 -> readdata = 0 and irq = 0 (no spurious edge). Read address 0 -> 32'h0000003F.
- in_port changes 6'h00 -> 6'h05; read address 0 every cycle -> readdata first shows 32'h00000005 exactly SYNC_STAGES+1 = 3 cycles after the change.
- EDGE_TYPE = 0, irqmask = 6'h04, rising edge on bit 2 -> edgecapture = 6'h04 and irq = 1 on the cycle after capture. Write 32'h4 to address 3 -> edgecapture = 0 and irq = 0 one cycle later.
- Rising edge on bit 1 in the same cycle as a write of 32'h2 to address 3 -> edgecapture bit 1 remains 1.
- EDGE_TYPE = 2: toggle bit 0 0->1->0 and clear between toggles -> each transition sets bit 0. A write to address 0 leaves the data register unchanged.
- irqmask = 6'h3F with edgecapture = 6'h01 pending, irq = 1; assert reset mid-cycle -> irq = 0, readdata = 0, irqmask = 0 immediately (asynchronous).
